// File: rtl/sha_msg_packer.sv
// Byte-stream to block packer for sha_1_core: packs bytes into words, appends 0x80/zero/bit-length
// padding and streams whole blocks. Define SHA_PACK_LITTLE_ENDIAN_EN for MD5-style lane and length order.
module sha_msg_packer #(
  parameter int DATA_W    = 32,
  parameter int BLK_WORDS = 16,
  parameter int LEN_W     = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [7:0]        byte_in,
  input  logic              byte_vld,
  input  logic              byte_last,
  output logic              byte_rdy,
  input  logic              core_busy,
  output logic [DATA_W-1:0] din,
  output logic              din_vld,
  output logic              use_pre_cv,
  output logic              sha_1_end,
  output logic              msg_busy
);

  localparam int BPW       = DATA_W / 8;
  localparam int BLK_BYTES = BLK_WORDS * BPW;
  localparam int LEN_BYTES = LEN_W / 8;
  localparam int PAD_LIM   = BLK_BYTES - LEN_BYTES;
  localparam int CNT_W     = $clog2(BLK_BYTES + 1);
  localparam int BIDX_W    = $clog2(BLK_BYTES);
  localparam int WIDX_W    = $clog2(BLK_WORDS);

  typedef enum logic [2:0] {
    S_FILL,
    S_PAD,
    S_LEN,
    S_SEND,
    S_CLR
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [7:0]          r_buf [BLK_BYTES];
  logic [CNT_W-1:0]    r_byte_cnt;
  logic [LEN_W-1:0]    r_bit_len;
  logic                r_first_blk;
  logic                r_fin;
  logic                r_pad_pend;
  logic                r_len_pend;
  logic [WIDX_W-1:0]   r_widx;
  logic                r_started;
  logic                r_msg_busy;

  logic                w_accept;
  logic                w_blk_full;
  logic                w_len_fits;
  logic                w_din_vld;
  logic                w_last_word;
  logic [BIDX_W-1:0]   w_wr_idx;
  logic [7:0]          w_len_bytes [LEN_BYTES];
  logic [DATA_W-1:0]   w_words [BLK_WORDS];

  assign byte_rdy    = (r_state == S_FILL);
  assign w_accept    = byte_vld & byte_rdy;
  assign w_wr_idx    = r_byte_cnt[BIDX_W-1:0];
  assign w_blk_full  = (r_byte_cnt == CNT_W'(BLK_BYTES));
  assign w_len_fits  = (r_byte_cnt < CNT_W'(PAD_LIM));
  // Once the first word goes out the block streams to the end regardless of core_busy.
  assign w_din_vld   = (r_state == S_SEND) && (r_started || !core_busy);
  assign w_last_word = (r_widx == WIDX_W'(BLK_WORDS - 1));

  // Length field as it lands in byte order within the tail of the block.
  always_comb begin
    for (int k = 0; k < LEN_BYTES; k++) begin
`ifdef SHA_PACK_LITTLE_ENDIAN_EN
      w_len_bytes[k] = r_bit_len[8*k +: 8];
`else
      w_len_bytes[k] = r_bit_len[8*(LEN_BYTES-1-k) +: 8];
`endif
    end
  end

  always_comb begin
    for (int w = 0; w < BLK_WORDS; w++) begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      w_words[w] = '0;
      for (int l = 0; l < BPW; l++) begin
`ifdef SHA_PACK_LITTLE_ENDIAN_EN
        w_words[w][8*l +: 8] = r_buf[w*BPW + l];
`else
        w_words[w][DATA_W-8-8*l +: 8] = r_buf[w*BPW + l];
`endif
      end
    end
  end

  assign din_vld    = w_din_vld;
  assign din        = w_din_vld ? w_words[r_widx] : '0;
  assign use_pre_cv = w_din_vld & ~r_first_blk;
  assign sha_1_end  = w_din_vld & r_fin;
  assign msg_busy   = r_msg_busy;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_FILL;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_FILL: begin
        if (w_accept) begin
          if (byte_last)                                 w_state_nxt = S_PAD;
          else if (r_byte_cnt == CNT_W'(BLK_BYTES - 1))  w_state_nxt = S_SEND;
        end
      end
      S_PAD:  w_state_nxt = (!w_blk_full && w_len_fits) ? S_LEN : S_SEND;
      S_LEN:  w_state_nxt = S_SEND;
      S_SEND: if (w_din_vld && w_last_word) w_state_nxt = S_CLR;
      S_CLR: begin
        if (r_pad_pend)      w_state_nxt = S_PAD;
        else if (r_len_pend) w_state_nxt = S_LEN;
        else                 w_state_nxt = S_FILL;
      end
      default: w_state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: the block buffer is reset as well, so a message after a mid-block reset sees only zero fill.
      for (int i = 0; i < BLK_BYTES; i++) r_buf[i] <= '0;
      r_byte_cnt  <= '0;
      r_bit_len   <= '0;
      r_first_blk <= 1'b1;
      r_fin       <= 1'b0;
      r_pad_pend  <= 1'b0;
      r_len_pend  <= 1'b0;
      r_widx      <= '0;
      r_started   <= 1'b0;
      r_msg_busy  <= 1'b0;
    end else begin
      unique case (r_state)
        S_FILL: begin
          if (w_accept) begin
            r_buf[w_wr_idx] <= byte_in;
            r_byte_cnt      <= r_byte_cnt + CNT_W'(1);
            r_bit_len       <= r_bit_len + LEN_W'(8);
            r_msg_busy      <= 1'b1;
          end
        end
        S_PAD: begin
          if (w_blk_full) begin
            r_pad_pend <= 1'b1;
          end else begin
            r_buf[w_wr_idx] <= 8'h80;
            r_byte_cnt      <= r_byte_cnt + CNT_W'(1);
            if (!w_len_fits) r_len_pend <= 1'b1;
          end
        end
        S_LEN: begin
          for (int k = 0; k < LEN_BYTES; k++) r_buf[PAD_LIM + k] <= w_len_bytes[k];
          r_fin <= 1'b1;
        end
        S_SEND: begin
          if (w_din_vld) begin
            if (w_last_word) begin
              r_widx    <= '0;
              r_started <= 1'b0;
            end else begin
              r_widx    <= r_widx + WIDX_W'(1);
              r_started <= 1'b1;
            end
          end
        end
        S_CLR: begin
          for (int i = 0; i < BLK_BYTES; i++) r_buf[i] <= '0;
          r_byte_cnt <= '0;
          r_pad_pend <= 1'b0;
          r_len_pend <= 1'b0;
          r_fin      <= 1'b0;
          if (r_fin) begin
            r_bit_len   <= '0;
            r_first_blk <= 1'b1;
            r_msg_busy  <= 1'b0;
          end else begin
            r_first_blk <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_msg_packer.sv
// Directed bench for sha_msg_packer: short, boundary-length and multi-block messages, core back-pressure
// and a reset in the middle of a block.
module tb_sha_msg_packer;

  logic        clk;
  logic        rstn;
  logic [7:0]  byte_in;
  logic        byte_vld;
  logic        byte_last;
  logic        byte_rdy;
  logic        core_busy;
  logic [31:0] din;
  logic        din_vld;
  logic        use_pre_cv;
  logic        sha_1_end;
  logic        msg_busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] got_w [16];
  logic [31:0] exp_w [16];
  logic        got_pre, got_end;
  int          got_lat;
  bit          got_rdy, got_gap;

  sha_msg_packer dut (
    .clk        (clk),
    .rstn       (rstn),
    .byte_in    (byte_in),
    .byte_vld   (byte_vld),
    .byte_last  (byte_last),
    .byte_rdy   (byte_rdy),
    .core_busy  (core_busy),
    .din        (din),
    .din_vld    (din_vld),
    .use_pre_cv (use_pre_cv),
    .sha_1_end  (sha_1_end),
    .msg_busy   (msg_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else             n_pass++;
  endtask

  // abc=1 sends 0x61,0x62,... otherwise n copies of fill; last marks the final byte.
  task automatic send_msg(input int n, input logic [7:0] fill, input bit abc);
    for (int i = 0; i < n; i++) begin
      int guard = 0;
      @(negedge clk);
      while (!byte_rdy && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      byte_in   = abc ? 8'(8'h61 + i) : fill;
      byte_vld  = 1'b1;
      byte_last = (i == n - 1);
      @(posedge clk);
      #1;
      byte_vld  = 1'b0;
      byte_last = 1'b0;
    end
  endtask

  // Waits for the first word (latency counted in negedges) then captures 16 consecutive words.
  task automatic get_block(input string tag);
    got_lat = 0;
    got_rdy = 0;
    got_gap = 0;
    for (int t = 1; t <= 300; t++) begin
      @(negedge clk);
      if (byte_rdy) got_rdy = 1;
      if (din_vld) begin
        got_lat = t;
        break;
      end
    end
    check({tag, "_arrived"}, 64'(got_lat != 0), 64'd1);
    if (got_lat == 0) begin
      for (int i = 0; i < 16; i++) got_w[i] = 32'hDEAD_BEEF;
      got_pre = 1'bx;
      got_end = 1'bx;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (i > 0) @(negedge clk);
        if (!din_vld) got_gap = 1;
        if (byte_rdy) got_rdy = 1;
        got_w[i] = din;
        if (i == 0) begin
          got_pre = use_pre_cv;
          got_end = sha_1_end;
        end else if (use_pre_cv !== got_pre || sha_1_end !== got_end) begin
          got_gap = 1;
        end
      end
      check({tag, "_contig"}, 64'(got_gap), 64'd0);
    end
  endtask

  task automatic check_words(input string tag);
    for (int i = 0; i < 16; i++) check($sformatf("%s_w%0d", tag, i), 64'(got_w[i]), 64'(exp_w[i]));
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 16; i++) exp_w[i] = 32'h0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    rstn      = 1'b0;
    byte_in   = 8'h00;
    byte_vld  = 1'b0;
    byte_last = 1'b0;
    core_busy = 1'b0;
    idle(3);
    check("rst_din_vld",  64'(din_vld),    64'd0);
    check("rst_din",      64'(din),        64'd0);
    check("rst_pre_cv",   64'(use_pre_cv), 64'd0);
    check("rst_end",      64'(sha_1_end),  64'd0);
    check("rst_msg_busy", 64'(msg_busy),   64'd0);
    check("rst_byte_rdy", 64'(byte_rdy),   64'd1);
    #2 rstn = 1'b1;

    // "abc": single block, 3-cycle latency from the last byte.
    send_msg(3, 8'h00, 1'b1);
    check("abc_busy", 64'(msg_busy), 64'd1);
    get_block("abc");
    clear_exp();
    exp_w[0]  = 32'h6162_6380;
    exp_w[15] = 32'h0000_0018;
    check("abc_lat", 64'(got_lat), 64'd3);
    check("abc_pre", 64'(got_pre), 64'd0);
    check("abc_end", 64'(got_end), 64'd1);
    check_words("abc");
    @(negedge clk);
    check("abc_clr_busy", 64'(msg_busy), 64'd1);
    @(negedge clk);
    check("abc_done_busy", 64'(msg_busy), 64'd0);
    check("abc_done_rdy",  64'(byte_rdy), 64'd1);

    // 55 bytes: 0x80 and length still fit in one block.
    send_msg(55, 8'h00, 1'b0);
    get_block("m55");
    clear_exp();
    exp_w[13] = 32'h0000_0080;
    exp_w[15] = 32'h0000_01B8;
    check("m55_pre", 64'(got_pre), 64'd0);
    check("m55_end", 64'(got_end), 64'd1);
    check_words("m55");
    idle(2);

    // 56 bytes: 0x80 fits, length spills into a second block.
    send_msg(56, 8'h00, 1'b0);
    get_block("m56a");
    clear_exp();
    exp_w[14] = 32'h8000_0000;
    check("m56a_pre", 64'(got_pre), 64'd0);
    check("m56a_end", 64'(got_end), 64'd0);
    check_words("m56a");
    get_block("m56b");
    clear_exp();
    exp_w[15] = 32'h0000_01C0;
    check("m56b_pre", 64'(got_pre), 64'd1);
    check("m56b_end", 64'(got_end), 64'd1);
    check_words("m56b");
    idle(2);

    // 64 bytes: full data block, then a padding-only block; no byte accepted meanwhile.
    send_msg(64, 8'h11, 1'b0);
    get_block("m64a");
    for (int i = 0; i < 16; i++) exp_w[i] = 32'h1111_1111;
    check("m64a_pre", 64'(got_pre), 64'd0);
    check("m64a_end", 64'(got_end), 64'd0);
    check("m64a_rdy", 64'(got_rdy), 64'd0);
    check_words("m64a");
    get_block("m64b");
    clear_exp();
    exp_w[0]  = 32'h8000_0000;
    exp_w[15] = 32'h0000_0200;
    check("m64b_pre", 64'(got_pre), 64'd1);
    check("m64b_end", 64'(got_end), 64'd1);
    check("m64b_rdy", 64'(got_rdy), 64'd0);
    check_words("m64b");
    @(negedge clk);
    check("m64_clr_rdy", 64'(byte_rdy), 64'd0);
    @(negedge clk);
    check("m64_done_rdy", 64'(byte_rdy), 64'd1);

    // Core busy holds off the block; it then streams contiguously.
    core_busy = 1'b1;
    send_msg(3, 8'h00, 1'b1);
    begin
      bit vld_seen = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (din_vld) vld_seen = 1;
      end
      check("busy_hold", 64'(vld_seen), 64'd0);
    end
    @(posedge clk);
    #1 core_busy = 1'b0;
    get_block("busy");
    clear_exp();
    exp_w[0]  = 32'h6162_6380;
    exp_w[15] = 32'h0000_0018;
    check("busy_lat", 64'(got_lat), 64'd1);
    check("busy_end", 64'(got_end), 64'd1);
    check_words("busy");
    idle(2);

    // Reset during word 5, then "abc" must come out exactly as before.
    send_msg(3, 8'h00, 1'b1);
    begin
      int t = 0;
      while (!din_vld && t < 300) begin
        @(negedge clk);
        t++;
      end
      check("rstmid_start", 64'(din_vld), 64'd1);
    end
    idle(5);
    rstn = 1'b0;
    #1;
    check("rstmid_vld",  64'(din_vld),  64'd0);
    check("rstmid_din",  64'(din),      64'd0);
    check("rstmid_busy", 64'(msg_busy), 64'd0);
    check("rstmid_rdy",  64'(byte_rdy), 64'd1);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    send_msg(3, 8'h00, 1'b1);
    get_block("post");
    clear_exp();
    exp_w[0]  = 32'h6162_6380;
    exp_w[15] = 32'h0000_0018;
    check("post_lat", 64'(got_lat), 64'd3);
    check("post_pre", 64'(got_pre), 64'd0);
    check("post_end", 64'(got_end), 64'd1);
    check_words("post");
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
